// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// The _c outputs are combinational; the perf counters are registered.
interface pipe_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 32
);
   logic              ext_hold;
   logic              ex_jump_req;
   logic [ADDR_W-1:0] ex_jump_addr;
   logic              ex_is_load;
   logic              ex_rd_we;
   logic [4:0]        ex_rd_addr;
   logic              id_rs1_re;
   logic [4:0]        id_rs1_addr;
   logic              id_rs2_re;
   logic [4:0]        id_rs2_addr;
   logic              mc_start;
   logic              mc_done;

   logic              hold_pc_c;
   logic              hold_if_id_c;
   logic              hold_id_ex_c;
   logic              flush_if_id_c;
   logic              flush_id_ex_c;
   logic              jump_ena_c;
   logic [ADDR_W-1:0] jump_addr_c;
   logic              timeout_c;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output ext_hold, ex_jump_req, ex_jump_addr, ex_is_load, ex_rd_we, ex_rd_addr,
             id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, mc_start, mc_done,
      input  hold_pc_c, hold_if_id_c, hold_id_ex_c, flush_if_id_c, flush_id_ex_c,
             jump_ena_c, jump_addr_c, timeout_c, stall_cnt, flush_cnt
   );

   modport slave (
      input  ext_hold, ex_jump_req, ex_jump_addr, ex_is_load, ex_rd_we, ex_rd_addr,
             id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, mc_start, mc_done,
      output hold_pc_c, hold_if_id_c, hold_id_ex_c, flush_if_id_c, flush_id_ex_c,
             jump_ena_c, jump_addr_c, timeout_c, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/flow controller for the 5-stage core: arbitrates bus stall, multi-cycle ops,
// EX jumps and load-use hazards into hold/flush/redirect controls, plus perf counters.
module pipe_ctrl #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 32
) (
   input logic        clk_100MHz,
   input logic        arst_n,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned MC_CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

   typedef enum logic [0:0] {ST_RUN, ST_MC_WAIT} state_t;

   state_t              state_q, state_d;
   logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
   logic                done_seen_q, done_seen_d;
   logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

   logic              hold_pc, hold_if_id, hold_id_ex;
   logic              flush_if_id, flush_id_ex, jump_ena, timeout;
   logic [ADDR_W-1:0] jump_addr;
   logic              lu;

   // Load-use: the load's rd is consumed by the instruction in ID.
   assign lu = bus.ex_is_load & bus.ex_rd_we & (bus.ex_rd_addr != 5'd0) &
               ((bus.id_rs1_re & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                (bus.id_rs2_re & (bus.id_rs2_addr == bus.ex_rd_addr)));

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= ST_RUN;
         mc_cnt_q    <= '0;
         done_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mc_cnt_q    <= mc_cnt_d;
         done_seen_q <= done_seen_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mc_cnt_d    = mc_cnt_q;
      done_seen_d = done_seen_q;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_ena    = 1'b0;
      jump_addr   = '0;
      timeout     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.ext_hold) begin
               hold_pc    = 1'b1;
               hold_if_id = 1'b1;
               hold_id_ex = 1'b1;
            end else if (bus.mc_start) begin
               hold_pc     = 1'b1;
               hold_if_id  = 1'b1;
               hold_id_ex  = 1'b1;
               state_d     = ST_MC_WAIT;
               mc_cnt_d    = '0;
               done_seen_d = 1'b0;
            end else if (bus.ex_jump_req) begin
               jump_ena    = 1'b1;
               jump_addr   = bus.ex_jump_addr;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else if (lu) begin
               hold_pc     = 1'b1;
               hold_if_id  = 1'b1;
               flush_id_ex = 1'b1;
            end
         end
         ST_MC_WAIT: begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            if ((bus.mc_done | done_seen_q) & ~bus.ext_hold) begin
               hold_pc     = 1'b0;
               hold_if_id  = 1'b0;
               hold_id_ex  = 1'b0;
               done_seen_d = 1'b0;
               state_d     = ST_RUN;
            end else if (bus.mc_done) begin
               done_seen_d = 1'b1;
            end else if (!bus.ext_hold && !done_seen_q) begin
               // Counter is frozen while the bus stalls; abandon the op on the last cycle.
               if (mc_cnt_q == MC_LAST) begin
                  timeout     = 1'b1;
                  hold_id_ex  = 1'b0;
                  flush_id_ex = 1'b1;
                  state_d     = ST_RUN;
               end else begin
                  mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Controls are forced low while reset is asserted, independent of the clock.
   assign bus.hold_pc_c     = arst_n & hold_pc;
   assign bus.hold_if_id_c  = arst_n & hold_if_id;
   assign bus.hold_id_ex_c  = arst_n & hold_id_ex;
   assign bus.flush_if_id_c = arst_n & flush_if_id;
   assign bus.flush_id_ex_c = arst_n & flush_id_ex;
   assign bus.jump_ena_c    = arst_n & jump_ena;
   assign bus.timeout_c     = arst_n & timeout;
   assign bus.jump_addr_c   = arst_n ? jump_addr : '0;

   // Saturating perf counters.
   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hold_pc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (jump_ena && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected controls are queued as each step is driven
// and popped when the combinational outputs settle; counters follow a saturating model.
module tb_pipe_ctrl;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned MC_TIMEOUT = 8;

   // Flag order: hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_ena, timeout
   localparam logic [6:0] F_NONE = 7'b000_0000;
   localparam logic [6:0] F_HOLD = 7'b111_0000;
   localparam logic [6:0] F_LU   = 7'b110_0100;
   localparam logic [6:0] F_JMP  = 7'b000_1110;
   localparam logic [6:0] F_TO   = 7'b110_0101;

   typedef struct packed {
      logic              hold_pc;
      logic              hold_if_id;
      logic              hold_id_ex;
      logic              flush_if_id;
      logic              flush_id_ex;
      logic              jump_ena;
      logic              timeout;
      logic [ADDR_W-1:0] jump_addr;
   } exp_t;

   logic clk_100MHz = 1'b0;
   logic arst_n;
   always #5 clk_100MHz = ~clk_100MHz;

   pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.ADDR_W(ADDR_W), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_100MHz (clk_100MHz),
      .arst_n     (arst_n),
      .bus        (bus)
   );

   exp_t             exp_q[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [CNT_W-1:0] stall_m, flush_m;

   function automatic exp_t mk(input logic [6:0] f, input logic [ADDR_W-1:0] a);
      return exp_t'({f, a});
   endfunction

   task automatic idle();
      bus.ext_hold     = 1'b0;
      bus.ex_jump_req  = 1'b0;
      bus.ex_jump_addr = '0;
      bus.ex_is_load   = 1'b0;
      bus.ex_rd_we     = 1'b0;
      bus.ex_rd_addr   = 5'd0;
      bus.id_rs1_re    = 1'b0;
      bus.id_rs1_addr  = 5'd0;
      bus.id_rs2_re    = 1'b0;
      bus.id_rs2_addr  = 5'd0;
      bus.mc_start     = 1'b0;
      bus.mc_done      = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic re1, input logic [4:0] rs1,
                           input logic re2, input logic [4:0] rs2);
      bus.ex_is_load  = 1'b1;
      bus.ex_rd_we    = 1'b1;
      bus.ex_rd_addr  = rd;
      bus.id_rs1_re   = re1;
      bus.id_rs1_addr = rs1;
      bus.id_rs2_re   = re2;
      bus.id_rs2_addr = rs2;
   endtask

   task automatic check_now(input string tag, output exp_t e);
      exp_t o;
      e = exp_q.pop_front();
      o = {bus.hold_pc_c, bus.hold_if_id_c, bus.hold_id_ex_c, bus.flush_if_id_c,
           bus.flush_id_ex_c, bus.jump_ena_c, bus.timeout_c, bus.jump_addr_c};
      n_cmp++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
      n_cmp++;
      assert (!(o.hold_if_id && o.flush_if_id) && !(o.hold_id_ex && o.flush_id_ex)) else begin
         n_fail++;
         $error("FAIL %s_excl: observed hold/flush overlap %h expected none", tag, o);
      end
   endtask

   task automatic check_cnt(input string tag);
      n_cmp++;
      assert ({bus.stall_cnt, bus.flush_cnt} === {stall_m, flush_m}) else begin
         n_fail++;
         $error("FAIL %s_cnt: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                tag, bus.stall_cnt, bus.flush_cnt, stall_m, flush_m);
      end
   endtask

   // Inputs are driven just after a rising edge; outputs checked on the falling edge.
   task automatic step(input logic [6:0] f, input logic [ADDR_W-1:0] a, input string tag);
      exp_t e;
      exp_q.push_back(mk(f, a));
      @(negedge clk_100MHz);
      check_now(tag, e);
      @(posedge clk_100MHz);
      #1;
      if (e.hold_pc && (stall_m != '1)) stall_m = stall_m + CNT_W'(1);
      if (e.jump_ena && (flush_m != '1)) flush_m = flush_m + CNT_W'(1);
      check_cnt(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [ADDR_W-1:0] a;
      arst_n  = 1'b0;
      stall_m = '0;
      flush_m = '0;
      idle();
      bus.ext_hold = 1'b1;
      #2;
      exp_q.push_back(mk(F_NONE, '0));
      check_now("rst_gate", e);
      check_cnt("rst");
      bus.ext_hold = 1'b0;
      @(negedge clk_100MHz);
      arst_n = 1'b1;
      @(posedge clk_100MHz);
      #1;
      step(F_NONE, '0, "idle0");

      // Load-use variants
      set_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);  step(F_LU,   '0, "lu_rs1");
      set_load(5'd7, 1'b0, 5'd0, 1'b1, 5'd7);  step(F_LU,   '0, "lu_rs2");
      set_load(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);  step(F_NONE, '0, "lu_rd0");
      set_load(5'd9, 1'b0, 5'd9, 1'b0, 5'd9);  step(F_NONE, '0, "lu_no_re");
      set_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
      bus.ex_is_load = 1'b0;                   step(F_NONE, '0, "lu_not_load");

      // Jump beats load-use; bus stall beats jump
      set_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
      bus.ex_jump_req = 1'b1;
      bus.ex_jump_addr = 32'h0000_0080;        step(F_JMP, 32'h80, "jump_over_lu");
      bus.ext_hold = 1'b1;                     step(F_HOLD, '0, "hold_over_jump");
      idle();                                  step(F_NONE, '0, "idle1");

      // Multi-cycle op completing on c4, jump/lu ignored while waiting
      bus.mc_start = 1'b1;                     step(F_HOLD, '0, "mc_c0");
      idle();
      bus.ex_jump_req = 1'b1; bus.ex_jump_addr = 32'h44;
      set_load(5'd3, 1'b1, 5'd3, 1'b0, 5'd0);  step(F_HOLD, '0, "mc_c1_ignore");
      idle();                                  step(F_HOLD, '0, "mc_c2");
                                               step(F_HOLD, '0, "mc_c3");
      bus.mc_done = 1'b1;                      step(F_NONE, '0, "mc_c4_done");
      idle();
      set_load(5'd3, 1'b1, 5'd3, 1'b0, 5'd0);  step(F_LU,   '0, "mc_c5_run");
      idle();

      // Timeout on the 8th wait cycle
      bus.mc_start = 1'b1;                     step(F_HOLD, '0, "to_start");
      idle();
      for (int i = 1; i < 8; i++)              step(F_HOLD, '0, $sformatf("to_wait%0d", i));
                                               step(F_TO,   '0, "to_fire");
      set_load(5'd4, 1'b0, 5'd0, 1'b1, 5'd4);  step(F_LU,   '0, "to_after_run");
      idle();

      // Done arriving under bus stall is remembered
      bus.mc_start = 1'b1;                     step(F_HOLD, '0, "ds_c0");
      idle();                                  step(F_HOLD, '0, "ds_c1");
      bus.ext_hold = 1'b1;                     step(F_HOLD, '0, "ds_c2");
      bus.mc_done = 1'b1;                      step(F_HOLD, '0, "ds_c3");
      bus.mc_done = 1'b0;                      step(F_HOLD, '0, "ds_c4");
                                               step(F_HOLD, '0, "ds_c5");
      bus.ext_hold = 1'b0;                     step(F_NONE, '0, "ds_c6_rel");
                                               step(F_NONE, '0, "ds_c7");

      // Bus stall freezes the timeout counter
      bus.mc_start = 1'b1;                     step(F_HOLD, '0, "fz_start");
      idle();
      for (int i = 0; i < 3; i++)              step(F_HOLD, '0, $sformatf("fz_pre%0d", i));
      bus.ext_hold = 1'b1;
      for (int i = 0; i < 10; i++)             step(F_HOLD, '0, $sformatf("fz_hold%0d", i));
      idle();
      for (int i = 0; i < 4; i++)              step(F_HOLD, '0, $sformatf("fz_post%0d", i));
                                               step(F_TO,   '0, "fz_fire");
                                               step(F_NONE, '0, "fz_idle");

      // Async reset in the middle of a wait
      bus.mc_start = 1'b1;                     step(F_HOLD, '0, "ar_start");
      idle();                                  step(F_HOLD, '0, "ar_wait");
      arst_n = 1'b0;
      #1;
      exp_q.push_back(mk(F_NONE, '0));
      check_now("ar_outs", e);
      stall_m = '0;
      flush_m = '0;
      check_cnt("ar");
      bus.mc_start = 1'b1;
      @(negedge clk_100MHz);
      exp_q.push_back(mk(F_NONE, '0));
      check_now("ar_start_gated", e);
      idle();
      arst_n = 1'b1;
      @(posedge clk_100MHz);
      #1;
      step(F_NONE, '0, "ar_idle_run");
      step(F_NONE, '0, "ar_idle_run2");

      // Counter saturation
      bus.ext_hold = 1'b1;
      for (int i = 0; i < 20; i++)             step(F_HOLD, '0, $sformatf("sat_hold%0d", i));
      n_cmp++;
      assert (bus.stall_cnt === 4'hF) else begin
         n_fail++;
         $error("FAIL stall_sat: observed %0d expected 15", bus.stall_cnt);
      end
      idle();
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         bus.ex_jump_req  = 1'b1;
         bus.ex_jump_addr = a;
         step(F_JMP, a, $sformatf("sat_jmp%0d", i));
      end
      n_cmp++;
      assert (bus.flush_cnt === 4'hF) else begin
         n_fail++;
         $error("FAIL flush_sat: observed %0d expected 15", bus.flush_cnt);
      end
      idle();
      step(F_NONE, '0, "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
